pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter next-state logic with a circular return-address
// stack. PC advances sequentially, follows PC-relative branches/calls,
// register-indirect jumps and returns, with a one-clock input-to-PC latency.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter int              RAS_DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              OFFSET_SHIFT = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            stall,
    input  logic [XLEN-1:0] sign_extend,
    input  logic            branch,
    input  logic            branch_nz,
    input  logic            zero,
    input  logic            uncondbranch,
    input  logic            call,
    input  logic            ret,
    input  logic            br_reg,
    input  logic [XLEN-1:0] reg_target,
    output logic [XLEN-1:0] PC,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
);

    // Pointer addresses a stack slot; count needs one extra code for "full".
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    localparam logic [PW-1:0] LAST_SLOT = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(RAS_DEPTH);

    // Stack storage; contents are never reset, only count/pointer are.
    logic [XLEN-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]   top_ptr;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] seq;
    logic [XLEN-1:0] rel;
    logic [XLEN-1:0] top;
    logic            taken;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;

    // Next-state values produced by the combinational block.
    logic [XLEN-1:0] pc_next;
    logic [PW-1:0]   ptr_next;
    logic [CW-1:0]   count_next;
    logic            err_next;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;

    assign seq   = PC + (XLEN'(1) << OFFSET_SHIFT);
    assign rel   = PC + (sign_extend << OFFSET_SHIFT);
    assign taken = uncondbranch | call | (branch & (zero ^ branch_nz));
    assign top   = stack[top_ptr];

    // Circular pointer arithmetic; depth need not be a power of two.
    assign ptr_inc = (top_ptr == LAST_SLOT) ? '0 : top_ptr + PW'(1);
    assign ptr_dec = (top_ptr == '0) ? LAST_SLOT : top_ptr - PW'(1);

    assign ras_empty = (count == '0);
    assign ras_full  = (count == FULL_CNT);

    // Next PC by priority plus stack push/pop/replace decisions.
    always_comb begin
        pc_next    = PC;
        ptr_next   = top_ptr;
        count_next = count;
        err_next   = ras_err;
        wr_en      = 1'b0;
        wr_idx     = ptr_inc;

        if (!stall) begin
            // Program counter selection.
            if (ret && !ras_empty) begin
                pc_next = top;
            end else if (ret) begin
                pc_next = seq;
            end else if (br_reg) begin
                pc_next = reg_target;
            end else if (taken) begin
                pc_next = rel;
            end else begin
                pc_next = seq;
            end

            // Return-address stack update.
            if (call && ret) begin
                if (ras_empty) begin
                    // Nothing to pop: behaves as a push and flags the underflow.
                    wr_en      = 1'b1;
                    wr_idx     = ptr_inc;
                    ptr_next   = ptr_inc;
                    count_next = CW'(1);
                    err_next   = 1'b1;
                end else begin
                    // Pop then push collapses into overwriting the top slot.
                    wr_en  = 1'b1;
                    wr_idx = top_ptr;
                end
            end else if (call) begin
                // When full, ptr_inc lands on the oldest entry, which is dropped.
                wr_en    = 1'b1;
                wr_idx   = ptr_inc;
                ptr_next = ptr_inc;
                if (ras_full) begin
                    err_next = 1'b1;
                end else begin
                    count_next = count + CW'(1);
                end
            end else if (ret) begin
                if (ras_empty) begin
                    err_next = 1'b1;
                end else begin
                    ptr_next   = ptr_dec;
                    count_next = count - CW'(1);
                end
            end
        end
    end

    // PC, stack pointer, count and sticky error register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            PC      <= RESET_PC;
            top_ptr <= '0;
            count   <= '0;
            ras_err <= 1'b0;
        end else begin
            PC      <= pc_next;
            top_ptr <= ptr_next;
            count   <= count_next;
            ras_err <= err_next;
        end
    end

    // Stack entry write; suppressed during reset so reset fully overrides a call.
    always_ff @(posedge clock) begin
        if (reset_n && wr_en) begin
            stack[wr_idx] <= seq;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected PC/stack state.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [31:0] sign_extend;
    logic        branch;
    logic        branch_nz;
    logic        zero;
    logic        uncondbranch;
    logic        call;
    logic        ret;
    logic        br_reg;
    logic [31:0] reg_target;
    logic [31:0] PC;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    int vectors     = 0;
    int miscompares = 0;

    pc_sequencer #(.XLEN(32), .RAS_DEPTH(4), .RESET_PC(32'h0), .OFFSET_SHIFT(2)) dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .sign_extend(sign_extend),
        .branch(branch), .branch_nz(branch_nz), .zero(zero), .uncondbranch(uncondbranch),
        .call(call), .ret(ret), .br_reg(br_reg), .reg_target(reg_target),
        .PC(PC), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_ctl();
        stall = 0; sign_extend = 0; branch = 0; branch_nz = 0; zero = 0;
        uncondbranch = 0; call = 0; ret = 0; br_reg = 0; reg_target = 0;
    endtask

    // One clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_ctl();
        reset_n = 0;
        tick();
        reset_n = 1;
    endtask

    // Jump to an address with br_reg; leaves the stack alone.
    task automatic load_pc(input logic [31:0] a);
        clear_ctl();
        br_reg = 1; reg_target = a;
        tick();
        clear_ctl();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
        vectors++; if ({ras_empty, ras_full, ras_err} !== 3'b100) begin miscompares++; $display("FAIL reset_flags: got %b want 100", {ras_empty, ras_full, ras_err}); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++; if (PC !== 32'(i * 4)) begin miscompares++; $display("FAIL seq_%0d: got %h want %h", i, PC, 32'(i * 4)); end
        end
    endtask

    task automatic test_branch();
        load_pc(32'h20);
        branch = 1; zero = 1; branch_nz = 0; sign_extend = 32'hFFFF_FFFE;
        tick();
        vectors++; if (PC !== 32'h18) begin miscompares++; $display("FAIL br_zero_taken: got %h want %h", PC, 32'h18); end
        load_pc(32'h20);
        branch = 1; zero = 1; branch_nz = 1; sign_extend = 32'hFFFF_FFFE;
        tick();
        vectors++; if (PC !== 32'h24) begin miscompares++; $display("FAIL br_nz_not_taken: got %h want %h", PC, 32'h24); end
        branch = 1; zero = 0; branch_nz = 1; sign_extend = 32'hFFFF_FFFE;
        tick();
        vectors++; if (PC !== 32'h1C) begin miscompares++; $display("FAIL br_nz_taken: got %h want %h", PC, 32'h1C); end
        clear_ctl();
        uncondbranch = 1; sign_extend = 32'h3;
        tick();
        vectors++; if (PC !== 32'h28) begin miscompares++; $display("FAIL uncond: got %h want %h", PC, 32'h28); end
        clear_ctl();
    endtask

    task automatic test_call_ret();
        do_reset();
        load_pc(32'h100);
        call = 1; sign_extend = 32'h40;
        tick();
        clear_ctl();
        vectors++; if (PC !== 32'h200) begin miscompares++; $display("FAIL call_pc: got %h want %h", PC, 32'h200); end
        vectors++; if (ras_empty !== 1'b0) begin miscompares++; $display("FAIL call_nonempty: got %b want 0", ras_empty); end
        ret = 1;
        tick();
        clear_ctl();
        vectors++; if (PC !== 32'h104) begin miscompares++; $display("FAIL ret_pc: got %h want %h", PC, 32'h104); end
        vectors++; if ({ras_empty, ras_err} !== 2'b10) begin miscompares++; $display("FAIL ret_flags: got %b want 10", {ras_empty, ras_err}); end
    endtask

    task automatic test_overflow();
        logic [31:0] rexp [4];
        rexp[0] = 32'h44; rexp[1] = 32'h34; rexp[2] = 32'h24; rexp[3] = 32'h14;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            call = 1; sign_extend = 32'h4;
            tick();
            if (i == 3) begin
                vectors++; if ({ras_full, ras_err} !== 2'b10) begin miscompares++; $display("FAIL fill_flags: got %b want 10", {ras_full, ras_err}); end
            end
        end
        clear_ctl();
        vectors++; if (PC !== 32'h50) begin miscompares++; $display("FAIL ovf_pc: got %h want %h", PC, 32'h50); end
        vectors++; if ({ras_full, ras_err} !== 2'b11) begin miscompares++; $display("FAIL ovf_flags: got %b want 11", {ras_full, ras_err}); end
        for (int i = 0; i < 4; i++) begin
            ret = 1;
            tick();
            vectors++; if (PC !== rexp[i]) begin miscompares++; $display("FAIL ovf_ret_%0d: got %h want %h", i, PC, rexp[i]); end
        end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL drained_empty: got %b want 1", ras_empty); end
        tick();
        clear_ctl();
        vectors++; if (PC !== 32'h18) begin miscompares++; $display("FAIL underflow_pc: got %h want %h", PC, 32'h18); end
        vectors++; if ({ras_empty, ras_err} !== 2'b11) begin miscompares++; $display("FAIL underflow_flags: got %b want 11", {ras_empty, ras_err}); end
    endtask

    task automatic test_call_ret_same();
        do_reset();
        call = 1; ret = 1; sign_extend = 32'h8;
        tick();
        clear_ctl();
        vectors++; if (PC !== 32'h4) begin miscompares++; $display("FAIL cr_empty_pc: got %h want %h", PC, 32'h4); end
        vectors++; if ({ras_empty, ras_err} !== 2'b01) begin miscompares++; $display("FAIL cr_empty_flags: got %b want 01", {ras_empty, ras_err}); end
        do_reset();
        call = 1; sign_extend = 32'h10;
        tick();
        call = 1; ret = 1; sign_extend = 32'h10;
        tick();
        clear_ctl();
        vectors++; if (PC !== 32'h4) begin miscompares++; $display("FAIL cr_pop_pc: got %h want %h", PC, 32'h4); end
        vectors++; if ({ras_empty, ras_err} !== 2'b00) begin miscompares++; $display("FAIL cr_pop_flags: got %b want 00", {ras_empty, ras_err}); end
        ret = 1;
        tick();
        clear_ctl();
        vectors++; if (PC !== 32'h44) begin miscompares++; $display("FAIL cr_replaced_top: got %h want %h", PC, 32'h44); end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL cr_final_empty: got %b want 1", ras_empty); end
    endtask

    task automatic test_br_reg_call();
        do_reset();
        load_pc(32'h80);
        br_reg = 1; call = 1; reg_target = 32'h300; sign_extend = 32'h10;
        tick();
        clear_ctl();
        vectors++; if (PC !== 32'h300) begin miscompares++; $display("FAIL brcall_pc: got %h want %h", PC, 32'h300); end
        ret = 1; br_reg = 1; reg_target = 32'h500;
        tick();
        clear_ctl();
        vectors++; if (PC !== 32'h84) begin miscompares++; $display("FAIL ret_over_brreg: got %h want %h", PC, 32'h84); end
    endtask

    task automatic test_stall();
        do_reset();
        call = 1; sign_extend = 32'h10;
        tick();
        for (int i = 0; i < 2; i++) begin
            stall = 1; call = 1; sign_extend = 32'h10;
            tick();
            vectors++; if (PC !== 32'h40) begin miscompares++; $display("FAIL stall_pc_%0d: got %h want %h", i, PC, 32'h40); end
        end
        clear_ctl();
        ret = 1;
        tick();
        vectors++; if (PC !== 32'h4) begin miscompares++; $display("FAIL stall_no_push: got %h want %h", PC, 32'h4); end
        stall = 1; ret = 1;
        tick();
        clear_ctl();
        vectors++; if ({PC, ras_err} !== {32'h4, 1'b0}) begin miscompares++; $display("FAIL stall_no_err: got %h/%b want 4/0", PC, ras_err); end
    endtask

    task automatic test_wrap();
        load_pc(32'hFFFF_FFFC);
        tick();
        vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL seq_wrap: got %h want %h", PC, 32'h0); end
        load_pc(32'hFFFF_FFF8);
        uncondbranch = 1; sign_extend = 32'h4;
        tick();
        clear_ctl();
        vectors++; if (PC !== 32'h8) begin miscompares++; $display("FAIL rel_wrap: got %h want %h", PC, 32'h8); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ret = 1;
        tick();
        call = 1; ret = 0; sign_extend = 32'h4;
        tick();
        clear_ctl();
        vectors++; if ({PC, ras_empty, ras_err} !== {32'h14, 1'b0, 1'b1}) begin miscompares++; $display("FAIL pre_reset: got %h/%b/%b want 14/0/1", PC, ras_empty, ras_err); end
        reset_n = 0; stall = 1; ret = 1;
        tick();
        vectors++; if ({PC, ras_empty, ras_full, ras_err} !== {32'h0, 3'b100}) begin miscompares++; $display("FAIL mid_reset: got %h/%b%b%b want 0/100", PC, ras_empty, ras_full, ras_err); end
        reset_n = 1;
        clear_ctl();
        tick();
        vectors++; if (PC !== 32'h4) begin miscompares++; $display("FAIL post_reset_seq: got %h want %h", PC, 32'h4); end
    endtask

    initial begin
        clear_ctl();
        reset_n = 0;
        test_reset();
        test_branch();
        test_call_ret();
        test_overflow();
        test_call_ret_same();
        test_br_reg_call();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
